// File: rtl/snake_step_ctrl.sv
// Snake game-step sequencer: applies direction, shifts the body RAM one segment per
// cycle with self-collision check, writes the new head, and tracks length/score/game-over.
module snake_step_ctrl #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int XW       = 6,
  parameter int YW       = 5,
  parameter int LW       = 6,
  parameter int MAX_LEN  = 63,
  parameter int INIT_LEN = 3
) (
  input  logic              snake_step_master_clk,
  input  logic              snake_step_reset_n,
  input  logic              snake_step_tick,
  input  logic              snake_step_restart,
  input  logic              snake_step_dir_valid,
  input  logic [1:0]        snake_step_dir,
  input  logic              snake_step_food_valid,
  input  logic [XW-1:0]     snake_step_food_x,
  input  logic [YW-1:0]     snake_step_food_y,
  output logic [LW-1:0]     snake_step_seg_addr,
  input  logic [XW+YW-1:0]  snake_step_seg_rdata,
  output logic              snake_step_seg_we,
  output logic [XW+YW-1:0]  snake_step_seg_wdata,
  output logic [XW-1:0]     snake_step_head_x,
  output logic [YW-1:0]     snake_step_head_y,
  output logic [LW-1:0]     snake_step_length,
  output logic [7:0]        snake_step_score,
  output logic              snake_step_food_eaten,
  output logic              snake_step_game_over,
  output logic              snake_step_busy
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CALC, S_SHIFT, S_HEAD, S_OVER} state_t;

  localparam logic [1:0]    D_UP    = 2'b00;
  localparam logic [1:0]    D_DOWN  = 2'b01;
  localparam logic [1:0]    D_LEFT  = 2'b10;
  localparam logic [1:0]    D_RIGHT = 2'b11;
  localparam logic [XW-1:0] CX      = XW'(GRID_W / 2);
  localparam logic [YW-1:0] CY      = YW'(GRID_H / 2);
  localparam logic [XW-1:0] XMAX    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX    = YW'(GRID_H - 1);
  localparam logic [LW-1:0] LINIT   = LW'(INIT_LEN);
  localparam logic [LW-1:0] LMAX    = LW'(MAX_LEN);

  state_t            state;
  logic [1:0]        cur_dir, pend_dir;
  logic [LW-1:0]     cnt, last;
  logic [XW-1:0]     nh_x, step_x;
  logic [YW-1:0]     nh_y, step_y;
  logic              grow, eat, hit;
  logic              off_grid, food_hit, grow_c, rd_match, dir_ok;
  logic [XW+YW-1:0]  wdata_q;

  always_comb begin
    step_x   = snake_step_head_x;
    step_y   = snake_step_head_y;
    off_grid = 1'b0;
    case (pend_dir)
      D_UP:    begin off_grid = (snake_step_head_y == '0);   step_y = snake_step_head_y - YW'(1); end
      D_DOWN:  begin off_grid = (snake_step_head_y == YMAX); step_y = snake_step_head_y + YW'(1); end
      D_LEFT:  begin off_grid = (snake_step_head_x == '0);   step_x = snake_step_head_x - XW'(1); end
      default: begin off_grid = (snake_step_head_x == XMAX); step_x = snake_step_head_x + XW'(1); end
    endcase
  end

  assign food_hit = snake_step_food_valid && (step_x == snake_step_food_x) &&
                    (step_y == snake_step_food_y);
  assign grow_c   = food_hit && (snake_step_length < LMAX);
  assign dir_ok   = snake_step_dir_valid && (snake_step_dir != (cur_dir ^ 2'b01));
  // Body walk runs head-to-tail on a read-first RAM: the write at addr a carries the
  // old seg[a-1] read the cycle before, so every old value is read before it is overwritten.
  assign rd_match = snake_step_seg_we && (snake_step_seg_rdata == {nh_x, nh_y});
  assign snake_step_busy      = !(state == S_IDLE || state == S_OVER);
  assign snake_step_seg_wdata = (state == S_SHIFT) ? snake_step_seg_rdata : wdata_q;

  always_ff @(posedge snake_step_master_clk or negedge snake_step_reset_n) begin
    if (!snake_step_reset_n) begin
      state <= S_INIT;  cnt <= '0;  last <= '0;
      cur_dir <= D_RIGHT;  pend_dir <= D_RIGHT;
      snake_step_head_x <= CX;  snake_step_head_y <= CY;
      snake_step_length <= LINIT;  snake_step_score <= '0;
      snake_step_seg_we <= 1'b0;  snake_step_seg_addr <= '0;  wdata_q <= '0;
      snake_step_food_eaten <= 1'b0;  snake_step_game_over <= 1'b0;
      nh_x <= '0;  nh_y <= '0;  grow <= 1'b0;  eat <= 1'b0;  hit <= 1'b0;
    end else if (snake_step_restart) begin
      state <= S_INIT;  cnt <= '0;  last <= '0;
      cur_dir <= D_RIGHT;  pend_dir <= D_RIGHT;
      snake_step_head_x <= CX;  snake_step_head_y <= CY;
      snake_step_length <= LINIT;  snake_step_score <= '0;
      snake_step_seg_we <= 1'b0;  snake_step_seg_addr <= '0;  wdata_q <= '0;
      snake_step_food_eaten <= 1'b0;  snake_step_game_over <= 1'b0;
      nh_x <= '0;  nh_y <= '0;  grow <= 1'b0;  eat <= 1'b0;  hit <= 1'b0;
    end else begin
      snake_step_food_eaten <= 1'b0;
      if (dir_ok) pend_dir <= snake_step_dir;
      case (state)
        S_INIT: begin
          if (cnt < LINIT) begin
            snake_step_seg_we   <= 1'b1;
            snake_step_seg_addr <= cnt;
            wdata_q             <= {CX - XW'(cnt), CY};
            cnt                 <= cnt + LW'(1);
          end else begin
            snake_step_seg_we   <= 1'b0;
            snake_step_seg_addr <= '0;
            state               <= S_IDLE;
          end
        end
        S_IDLE: if (snake_step_tick) state <= S_CALC;
        S_CALC: begin
          cur_dir <= pend_dir;
          if (off_grid) begin
            snake_step_game_over <= 1'b1;
            state                <= S_OVER;
          end else begin
            nh_x <= step_x;  nh_y <= step_y;
            grow <= grow_c;  eat <= food_hit;  hit <= 1'b0;
            last <= grow_c ? snake_step_length : snake_step_length - LW'(1);
            cnt  <= '0;
            snake_step_seg_addr <= '0;
            snake_step_seg_we   <= 1'b0;
            state               <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (rd_match) hit <= 1'b1;
          if (cnt == last) begin
            snake_step_seg_addr <= '0;
            snake_step_seg_we   <= !(hit || rd_match);
            wdata_q             <= {nh_x, nh_y};
            state               <= S_HEAD;
          end else begin
            cnt                 <= cnt + LW'(1);
            snake_step_seg_addr <= cnt + LW'(1);
            snake_step_seg_we   <= 1'b1;
          end
        end
        S_HEAD: begin
          snake_step_seg_we <= 1'b0;
          if (hit) begin
            snake_step_game_over <= 1'b1;
            state                <= S_OVER;
          end else begin
            snake_step_head_x     <= nh_x;
            snake_step_head_y     <= nh_y;
            snake_step_length     <= snake_step_length + LW'(grow);
            if (eat && snake_step_score != 8'hFF) snake_step_score <= snake_step_score + 8'd1;
            snake_step_food_eaten <= eat;
            state                 <= S_IDLE;
          end
        end
        S_OVER: ;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
